hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the IF/ID/EX front end. Drives the en and bubble controls of the ID stage and the IF/PC enable.
//  Inserts one bubble on a load-use hazard. Freezes the pipe while the data memory has not acknowledged an access.
//  Traps a memory access that never completes.
// PARAMETERS
//  RF_SIZE       5    register index width
//  WAIT_W        4    width of memory-wait counter
//  MAX_MEM_WAIT  15   cycles in MEM_WAIT before timeout; must be < 2**WAIT_W
//  CNT_W         32   perf counter width (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst            in   1        synchronous reset, active-high
//  id_valid       in   1        IF/ID register holds a valid instruction
//  id_opcode      in   7        opcode of instruction in ID
//  id_rs1         in   RF_SIZE  rs1 of instruction in ID
//  id_rs2         in   RF_SIZE  rs2 of instruction in ID
//  ex_rd          in   RF_SIZE  rd of instruction in EX
//  ex_mem_re      in   1        instruction in EX is a load
//  dmem_req       in   1        MEM stage access request (held until ack)
//  dmem_ack       in   1        data memory completes access this cycle
//  if_en          out  1        PC / IF-ID register advance
//  id_en          out  1        ID-EX register load (id_stage en)
//  id_bubble      out  1        ID-EX register clear (id_stage bubble)
//  stall          out  1        pipe not advancing normally this cycle
//  timeout_err    out  1        sticky memory-timeout flag
//  lu_stall_cnt   out  CNT_W    load-use bubbles inserted (macro only)
//  mem_wait_cnt   out  CNT_W    cycles frozen on memory (macro only)
// BEHAVIOUR
//  - Source operand use by opcode:
//    - 0110011 (R-type) and 0100011 (store): rs1 and rs2.
//    - 0010011 (I-type) and 0000011 (load): rs1 only.
//    - Any other opcode: neither.
//  - lu_haz = id_valid & ex_mem_re & ex_rd!=0 & ((use1 & ex_rd==id_rs1) | (use2 & ex_rd==id_rs2)).
//  - mem_busy = dmem_req & ~dmem_ack.
//  - FSM states: RUN, MEM_WAIT, ERR.
//  - Outputs are combinational from state and inputs (Mealy). Zero-latency response, same cycle.
//  - RUN:
//    - mem_busy: freeze. if_en=0, id_en=0, id_bubble=0. Go to MEM_WAIT, wait_cnt<=1.
//    - else lu_haz: if_en=0, id_en=0, id_bubble=1. Stay in RUN.
//    - else: if_en=1, id_en=1, id_bubble=0.
//  - MEM_WAIT:
//    - dmem_ack=1: release this cycle with the RUN non-busy rules (lu_haz still bubbles). Go to RUN, wait_cnt<=0.
//    - dmem_ack=0 and wait_cnt==MAX_MEM_WAIT: go to ERR, timeout_err<=1.
//    - otherwise: stay frozen, wait_cnt++.
//  - ERR: if_en=0, id_en=0, id_bubble=0, timeout_err=1. Left only by rst.
//  - Priority: memory freeze > load-use bubble > advance. A bubble is never issued while frozen, because that would drop the ID instruction.
//  - stall = ~if_en.
//  - rst has priority over everything. While rst=1: if_en=0, id_en=0, id_bubble=1, stall=1.
//  - Registered reset values: state=RUN, wait_cnt=0, timeout_err=0, counters=0.
//  - rst mid-MEM_WAIT: return to RUN; the outstanding access is abandoned.
//  - The hazard check for ex_rd==0 is never true (x0 is not a hazard).
//  - dmem_req and dmem_ack high in the same cycle in RUN is not busy: no freeze.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    - lu_stall_cnt increments on each cycle with id_bubble=1 and rst=0.
//    - mem_wait_cnt increments on each frozen cycle in RUN or MEM_WAIT.
//    - Both saturate at all-ones and clear on rst.
//  HAZARD_PERF_CNT_EN undefined: counter ports and logic absent. All other behaviour identical.
// TESTING
//  1. Load x5 in EX (ex_mem_re=1, ex_rd=5); ID holds add rs2=5.
//     -> one cycle if_en=0, id_en=0, id_bubble=1. Next cycle (ex_mem_re=0) full advance.
//  2. Same as 1 but ex_rd=0, or ID opcode=0010011 with rs2=5 and rs1=3.
//     -> no bubble, if_en=id_en=1.
//  3. dmem_req=1, ack arrives after 3 cycles.
//     -> 3 cycles if_en=id_en=id_bubble=0, state MEM_WAIT. Ack cycle if_en=id_en=1. mem_wait_cnt=3.
//  4. Memory freeze coincident with lu_haz.
//     -> frozen with id_bubble=0 throughout. Bubble issued on the ack cycle only.
//  5. dmem_req held, never acked.
//     -> timeout_err=1 after MAX_MEM_WAIT+1 frozen cycles, enables stay 0. rst clears it to RUN.
//  6. rst asserted during MEM_WAIT.
//     -> next cycle state RUN, timeout_err=0, counters 0. id_bubble=1 while rst=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Pipeline sequencer for the IF/ID/EX front end. It generates
//             the IF/PC enable and the ID-stage enable and bubble controls.
//             A load-use hazard inserts a single bubble. The pipe freezes
//             while a data-memory access is still unacknowledged. An access
//             that never completes is trapped into a sticky error state.
//  Options  : HAZARD_PERF_CNT_EN -- adds saturating counters for load-use
//             bubbles and memory-freeze cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int RF_SIZE      = 5,
    parameter int WAIT_W       = 4,
    parameter int MAX_MEM_WAIT = 15
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid_i,
    input  logic [6:0]         id_opcode_i,
    input  logic [RF_SIZE-1:0] id_rs1_i,
    input  logic [RF_SIZE-1:0] id_rs2_i,
    input  logic [RF_SIZE-1:0] ex_rd_i,
    input  logic               ex_mem_re_i,
    input  logic               dmem_req_i,
    input  logic               dmem_ack_i,
    output logic               if_en_o,
    output logic               id_en_o,
    output logic               id_bubble_o,
    output logic               stall_o,
    output logic               timeout_err_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   lu_stall_cnt_o,
    output logic [CNT_W-1:0]   mem_wait_cnt_o
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_MEM_WAIT);

    logic [1:0]        state_q,   state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    logic w_use1;
    logic w_use2;
    logic w_lu_haz;
    logic w_mem_busy;
    logic w_frozen;

    // Operand-use decode and hazard detection; x0 never creates a hazard.
    always_comb begin
        w_use1 = (id_opcode_i == OP_RTYPE) || (id_opcode_i == OP_STORE) ||
                 (id_opcode_i == OP_ITYPE) || (id_opcode_i == OP_LOAD);
        w_use2 = (id_opcode_i == OP_RTYPE) || (id_opcode_i == OP_STORE);
        w_lu_haz = id_valid_i && ex_mem_re_i && (ex_rd_i != '0) &&
                   ((w_use1 && (ex_rd_i == id_rs1_i)) ||
                    (w_use2 && (ex_rd_i == id_rs2_i)));
        w_mem_busy = dmem_req_i && !dmem_ack_i;
    end

    // State register: sequencer state, memory-wait counter, sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic: enter MEM_WAIT on a busy access, exit on ack or timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (w_mem_busy) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == C_MAX_WAIT) begin
                    state_d   = ST_ERR;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Mealy outputs: freeze beats bubble beats advance; a bubble while frozen
    // would discard the instruction held in ID, so it waits for the ack cycle.
    always_comb begin
        if_en_o     = 1'b0;
        id_en_o     = 1'b0;
        id_bubble_o = 1'b0;
        w_frozen    = 1'b0;
        if (rst) begin
            id_bubble_o = 1'b1;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if ((state_q == ST_RUN) ? w_mem_busy : !dmem_ack_i) begin
                        w_frozen = 1'b1;
                    end else if (w_lu_haz) begin
                        id_bubble_o = 1'b1;
                    end else begin
                        if_en_o = 1'b1;
                        id_en_o = 1'b1;
                    end
                end
                default: begin
                    w_frozen = 1'b0;
                end
            endcase
        end
        stall_o       = !if_en_o;
        timeout_err_o = timeout_q;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_stall_cnt_q;
    logic [CNT_W-1:0] mem_wait_cnt_q;

    // Saturating performance counters for bubbles and memory-freeze cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_stall_cnt_q <= '0;
            mem_wait_cnt_q <= '0;
        end else begin
            if (id_bubble_o && (lu_stall_cnt_q != '1)) begin
                lu_stall_cnt_q <= lu_stall_cnt_q + CNT_W'(1);
            end
            if (w_frozen && (mem_wait_cnt_q != '1)) begin
                mem_wait_cnt_q <= mem_wait_cnt_q + CNT_W'(1);
            end
        end
    end

    assign lu_stall_cnt_o = lu_stall_cnt_q;
    assign mem_wait_cnt_o = mem_wait_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Directed self-checking bench for hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_re;
    logic       dmem_req;
    logic       dmem_ack;
    logic       if_en;
    logic       id_en;
    logic       id_bubble;
    logic       stall;
    logic       timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_stall_cnt;
    logic [31:0] mem_wait_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Expected output vectors: {if_en, id_en, id_bubble, stall, timeout_err}
    localparam logic [4:0] ADV    = 5'b11000;
    localparam logic [4:0] BUB    = 5'b00110;
    localparam logic [4:0] FRZ    = 5'b00010;
    localparam logic [4:0] RSTV   = 5'b00110;
    localparam logic [4:0] RSTV_T = 5'b00111;
    localparam logic [4:0] ERRV   = 5'b00011;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_J  = 7'b1101111;

    hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id_valid),
        .id_opcode_i   (id_opcode),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .ex_rd_i       (ex_rd),
        .ex_mem_re_i   (ex_mem_re),
        .dmem_req_i    (dmem_req),
        .dmem_ack_i    (dmem_ack),
        .if_en_o       (if_en),
        .id_en_o       (id_en),
        .id_bubble_o   (id_bubble),
        .stall_o       (stall),
        .timeout_err_o (timeout_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .lu_stall_cnt_o(lu_stall_cnt),
        .mem_wait_cnt_o(mem_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {if_en, id_en, id_bubble, stall, timeout_err};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {if,id,bub,stall,to}=%b expected %b", tag, obs, exp);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
`endif

    // Check same-cycle outputs for the inputs just driven, then advance one cycle.
    task automatic step(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, exp);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd, input logic re);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = r1;
        id_rs2    = r2;
        ex_rd     = rd;
        ex_mem_re = re;
    endtask

    initial begin
        rst = 1'b1;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        dmem_req = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step("reset_outputs", RSTV);
`ifdef HAZARD_PERF_CNT_EN
        chk_cnt("reset_lu_cnt", lu_stall_cnt, 32'd0);
        chk_cnt("reset_mw_cnt", mem_wait_cnt, 32'd0);
`endif
        rst = 1'b0;
        step("idle_advance", ADV);

        // Load-use on rs2 of an R-type: one bubble, then advance.
        set_id(1'b1, OP_R, 5'd1, 5'd5, 5'd5, 1'b1);
        step("lu_rtype_rs2", BUB);
        ex_mem_re = 1'b0;
        step("lu_release", ADV);

        // Non-hazards: x0, I-type ignores rs2, unknown opcode, invalid ID.
        set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd0, 1'b1);
        step("lu_x0", ADV);
        set_id(1'b1, OP_I, 5'd3, 5'd5, 5'd5, 1'b1);
        step("lu_itype_rs2", ADV);
        set_id(1'b1, OP_J, 5'd5, 5'd5, 5'd5, 1'b1);
        step("lu_other_op", ADV);
        set_id(1'b0, OP_R, 5'd5, 5'd5, 5'd5, 1'b1);
        step("lu_id_invalid", ADV);

        // Hazards via I-type rs1 and store rs2.
        set_id(1'b1, OP_I, 5'd5, 5'd3, 5'd5, 1'b1);
        step("lu_itype_rs1", BUB);
        set_id(1'b1, OP_S, 5'd3, 5'd5, 5'd5, 1'b1);
        step("lu_store_rs2", BUB);

        // req and ack together in RUN is not busy.
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        dmem_req = 1'b1;
        dmem_ack = 1'b1;
        step("req_ack_same", ADV);
        dmem_req = 1'b0;
        dmem_ack = 1'b0;
        step("after_req_ack", ADV);

        // Memory freeze for three cycles, release on ack.
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_freeze", FRZ);
        dmem_ack = 1'b1;
        step("mem_ack", ADV);
        dmem_req = 1'b0;
        dmem_ack = 1'b0;
        step("mem_after", ADV);
`ifdef HAZARD_PERF_CNT_EN
        chk_cnt("mw_cnt_3", mem_wait_cnt, 32'd3);
        chk_cnt("lu_cnt_3", lu_stall_cnt, 32'd3);
`endif

        // Freeze coincident with load-use: bubble only on the ack cycle.
        set_id(1'b1, OP_R, 5'd2, 5'd7, 5'd7, 1'b1);
        dmem_req = 1'b1;
        for (int i = 0; i < 2; i++) step("frz_lu_hold", FRZ);
        dmem_ack = 1'b1;
        step("frz_lu_ack_bubble", BUB);
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        dmem_req = 1'b0;
        dmem_ack = 1'b0;
        step("frz_lu_after", ADV);
`ifdef HAZARD_PERF_CNT_EN
        chk_cnt("lu_cnt_4", lu_stall_cnt, 32'd4);
        chk_cnt("mw_cnt_5", mem_wait_cnt, 32'd5);
`endif

        // Never-acked access: 16 frozen cycles, then sticky error.
        dmem_req = 1'b1;
        for (int i = 0; i < 16; i++) step("timeout_wait", FRZ);
        step("timeout_err", ERRV);
        dmem_ack = 1'b1;
        set_id(1'b1, OP_R, 5'd5, 5'd5, 5'd5, 1'b1);
        step("err_sticky_ack", ERRV);
        rst = 1'b1;
        step("err_rst_cycle", RSTV_T);
        step("err_rst_cleared", RSTV);
`ifdef HAZARD_PERF_CNT_EN
        chk_cnt("rst_lu_cnt", lu_stall_cnt, 32'd0);
        chk_cnt("rst_mw_cnt", mem_wait_cnt, 32'd0);
`endif
        rst = 1'b0;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        dmem_req = 1'b0;
        dmem_ack = 1'b0;
        step("err_recovered", ADV);

        // Reset during MEM_WAIT abandons the access and returns to RUN.
        dmem_req = 1'b1;
        for (int i = 0; i < 2; i++) step("mw_pre_rst", FRZ);
        rst = 1'b1;
        step("mw_rst", RSTV);
        rst = 1'b0;
        dmem_req = 1'b0;
        step("mw_rst_run", ADV);
        dmem_req = 1'b1;
        step("mw_rst_refreeze", FRZ);
        dmem_ack = 1'b1;
        step("mw_rst_reack", ADV);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
